page_list_manager: RTL and testbench

PAGE_LIST_MANAGER -- requirements
Module: page_list_manager

---
 rtl/page_list_manager_pkg.sv | 11 +
 rtl/page_next_ram.sv | 25 ++
 rtl/page_list_manager.sv | 144 ++++++++++++++
 tb/tb_page_list_manager.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/page_list_manager_pkg.sv
// Shared definitions for the linked page-list manager: FSM encoding and default sizing.
package page_list_manager_pkg;

    localparam int ADDR_PAGE_NUM_LOG_DEF = 12;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } pl_state_t;

endpackage

// File: rtl/page_next_ram.sv
// Next-pointer storage for the page list: one synchronous write port, one asynchronous read port.
module page_next_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/page_list_manager.sv
// Singly linked page list (head/tail/count plus next-pointer RAM); used both as the
// preloaded free-page list (INIT_FULL=1) and as an initially empty data-page list.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_INIT | building the list; with INIT_FULL chain next[i]=i+1, requests ignored
// ST_IDLE | serving push/pop requests
module page_list_manager
    import page_list_manager_pkg::*;
#(
    parameter int ADDR_PAGE_NUM_LOG = ADDR_PAGE_NUM_LOG_DEF,
    parameter bit INIT_FULL         = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         read_req,
    input  logic                         write_req,
    input  logic [ADDR_PAGE_NUM_LOG-1:0] write_addr,
    output logic [ADDR_PAGE_NUM_LOG-1:0] read_addr,
    output logic [ADDR_PAGE_NUM_LOG-1:0] read_last_addr,
    output logic                         empty,
    output logic                         full,
    output logic [ADDR_PAGE_NUM_LOG:0]   page_count,
    output logic                         init_done,
    output logic                         underflow,
    output logic                         overflow
);

    localparam int AW = ADDR_PAGE_NUM_LOG;
    localparam logic [AW:0] PAGE_NUM = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

    pl_state_t state, state_next;

    logic [AW:0]   init_idx;
    logic [AW:0]   init_idx_inc;
    logic [AW:0]   count;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] head_next_ptr;
    logic          idle;
    logic          init_last;
    logic          init_wr;
    logic          do_pop;
    logic          do_push;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [AW-1:0] ram_wdata;

    assign idle         = (state == ST_IDLE);
    assign init_idx_inc = init_idx + CNT_ONE;
    assign init_last    = (init_idx == PAGE_NUM);
    assign init_wr      = (state == ST_INIT) && INIT_FULL && !init_last;

    // A push into a full list is still legal when a pop frees a slot in the same cycle.
    assign do_pop  = idle && read_req && (count != '0);
    assign do_push = idle && write_req && ((count != PAGE_NUM) || read_req);

    assign ram_we    = init_wr || do_push;
    assign ram_waddr = init_wr ? init_idx[AW-1:0]     : tail;
    assign ram_wdata = init_wr ? init_idx_inc[AW-1:0] : write_addr;

    page_next_ram #(
        .ADDR_W (AW)
    ) u_next_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (head),
        .rdata (head_next_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: begin
                if (!INIT_FULL || init_last) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: state_next = ST_IDLE;
            default: state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_idx  <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else if (state == ST_INIT) begin
            if (INIT_FULL) begin
                if (!init_last) begin
                    init_idx <= init_idx_inc;
                end else begin
                    head  <= '0;
                    tail  <= '1;
                    count <= PAGE_NUM;
                end
            end
        end else begin
            if (read_req && (count == '0)) begin
                underflow <= 1'b1;
            end
            if (write_req && !read_req && (count == PAGE_NUM)) begin
                overflow <= 1'b1;
            end
            if (do_push) begin
                tail <= write_addr;
            end
            // With one page left, a concurrent pop would follow a stale next pointer.
            if (do_push && ((count == '0) || (do_pop && (count == CNT_ONE)))) begin
                head <= write_addr;
            end else if (do_pop) begin
                head <= head_next_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

    assign read_addr      = head;
    assign read_last_addr = tail;
    assign empty          = (count == '0);
    assign full           = (count == PAGE_NUM);
    assign page_count     = count;
    assign init_done      = idle;

endmodule

// File: tb/tb_page_list_manager.sv
// Bench for page_list_manager: a free list (INIT_FULL=1) and a data list (INIT_FULL=0),
// each checked against a queue holding the expected page order.
module tb_page_list_manager;

    localparam int AW = 3;
    localparam int N  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          read_req       [2];
    logic          write_req      [2];
    logic [AW-1:0] write_addr     [2];
    logic [AW-1:0] read_addr      [2];
    logic [AW-1:0] read_last_addr [2];
    logic          empty          [2];
    logic          full           [2];
    logic [AW:0]   page_count     [2];
    logic          init_done      [2];
    logic          underflow      [2];
    logic          overflow       [2];

    int n_checks = 0;
    int n_errors = 0;
    int model_q[$];
    bit exp_unf[2];
    bit exp_ovf[2];
    int edges;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        page_list_manager #(
            .ADDR_PAGE_NUM_LOG (AW),
            .INIT_FULL         (g == 0)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .read_req       (read_req[g]),
            .write_req      (write_req[g]),
            .write_addr     (write_addr[g]),
            .read_addr      (read_addr[g]),
            .read_last_addr (read_last_addr[g]),
            .empty          (empty[g]),
            .full           (full[g]),
            .page_count     (page_count[g]),
            .init_done      (init_done[g]),
            .underflow      (underflow[g]),
            .overflow       (overflow[g])
        );
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state(input int l);
        check("init_done", init_done[l], 1);
        check("page_count", page_count[l], model_q.size());
        check("empty", empty[l], (model_q.size() == 0) ? 1 : 0);
        check("full", full[l], (model_q.size() == N) ? 1 : 0);
        check("underflow", underflow[l], exp_unf[l]);
        check("overflow", overflow[l], exp_ovf[l]);
        if (model_q.size() > 0) begin
            check("read_addr", read_addr[l], model_q[0]);
            check("read_last_addr", read_last_addr[l], model_q[model_q.size()-1]);
        end
    endtask

    // One request cycle on list l; expectations come from the page-order queue.
    task automatic op(input int l, input bit rd, input bit wr, input int addr);
        int cnt;
        int exp_page;
        cnt = model_q.size();
        read_req[l]   = rd;
        write_req[l]  = wr;
        write_addr[l] = addr[AW-1:0];
        if (rd) begin
            if (cnt == 0) begin
                exp_unf[l] = 1'b1;
            end else begin
                exp_page = model_q.pop_front();
                check("pop_page", read_addr[l], exp_page);
            end
        end
        if (wr) begin
            if (cnt == N && !rd) exp_ovf[l] = 1'b1;
            else model_q.push_back(addr);
        end
        @(posedge clk);
        #1;
        read_req[l]  = 1'b0;
        write_req[l] = 1'b0;
        check_state(l);
    endtask

    initial begin
        rst = 1'b1;
        for (int l = 0; l < 2; l++) begin
            read_req[l]   = 1'b0;
            write_req[l]  = 1'b0;
            write_addr[l] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int l = 0; l < 2; l++) begin
            check("rst_init_done", init_done[l], 0);
            check("rst_empty", empty[l], 1);
            check("rst_full", full[l], 0);
            check("rst_count", page_count[l], 0);
            check("rst_underflow", underflow[l], 0);
            check("rst_overflow", overflow[l], 0);
        end

        rst = 1'b0;
        @(posedge clk);
        #1;
        check("data_init_done", init_done[1], 1);
        check("free_init_busy", init_done[0], 0);
        check("free_init_empty", empty[0], 1);
        check("free_init_full", full[0], 0);

        // Restart INIT partway through, hammering requests that must be ignored.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("free_restart_busy", init_done[0], 0);
        edges = 0;
        while (edges < 20) begin
            read_req[0]   = 1'b1;
            write_req[0]  = 1'b1;
            write_addr[0] = 3'd5;
            @(posedge clk);
            #1;
            edges++;
            if (init_done[0]) break;
        end
        read_req[0]  = 1'b0;
        write_req[0] = 1'b0;
        check("init_latency", edges, 9);

        exp_unf[0] = 1'b0;
        exp_ovf[0] = 1'b0;
        exp_unf[1] = 1'b0;
        exp_ovf[1] = 1'b0;
        model_q.delete();
        for (int p = 0; p < N; p++) model_q.push_back(p);
        check_state(0);

        for (int p = 0; p < N; p++) op(0, 1'b1, 1'b0, 0);
        op(0, 1'b1, 1'b0, 0);

        model_q.delete();
        check_state(1);
        op(1, 1'b0, 1'b1, 5);
        op(1, 1'b0, 1'b1, 2);
        op(1, 1'b0, 1'b1, 6);
        repeat (3) op(1, 1'b1, 1'b0, 0);
        op(1, 1'b1, 1'b1, 3);
        op(1, 1'b1, 1'b1, 4);
        op(1, 1'b1, 1'b1, 7);
        for (int p = 0; p < 7; p++) op(1, 1'b0, 1'b1, p);
        op(1, 1'b1, 1'b1, 7);
        op(1, 1'b0, 1'b1, 3);
        repeat (N) op(1, 1'b1, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
